gray_tracker: RTL and testbench
===============================

Name: gray_tracker

Overview:
- Receive-side companion to the design's 3-bit Gray-code counter.
- Samples a Gray-coded count bus on strobe and decodes it to binary.
- Checks every accepted sample is either a repeat or a legal +1 step, and counts wrap-arounds.
- Flags illegal jumps so upstream counter or CDC faults are visible to the rest of the datapath.

Parameters:
- WIDTH, 3, width of the Gray input and binary output.
- WRAP_W, 4, width of the wrap-around counter.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  sample strobe; GrayIn is evaluated only on cycles with En=1.
- GrayIn  input  WIDTH  Gray-coded count from the sender.
- Binary  output  WIDTH  registered decoded value of the last accepted sample.
- Step  output  1  one-cycle pulse: a legal +1 advance was accepted.
- Wraps  output  WRAP_W  number of accepted all-ones to zero transitions, saturating.
- Overflow  output  1  sticky: at least one wrap accepted since reset.
- Locked  output  1  tracker has a valid reference value.
- Error  output  1  sticky: an illegal transition was seen.

Behaviour:
- Clock and reset: Clk; reset Reset, synchronous, active-high.
- Reset has priority over En.
- Reset values and power-up initial values are identical: Binary=0, Step=0, Wraps=0, Overflow=0, Locked=0, Error=0, state=UNLOCKED.
- Decode (combinational on GrayIn): dec[WIDTH-1]=GrayIn[WIDTH-1]; dec[i]=dec[i+1]^GrayIn[i].
- All outputs are registered, so latency is 1 cycle from the sampling edge.
- Step defaults to 0 every cycle; it is high only in the cycle after an accepted advance.
- En=0: all state and outputs hold, except Step, which returns to 0.
- State UNLOCKED (Locked=0):
  - On En: Binary<=dec, go to LOCKED.
  - No Step pulse, no wrap check.
- State LOCKED (Locked=1), on En, with d = dec - Binary modulo 2^WIDTH:
  - d==0: repeated sample, legal. Nothing changes; Step=0.
  - d==1: Binary<=dec, Step<=1.
    - If old Binary was all ones (new value 0): Overflow<=1 and Wraps<=Wraps+1.
    - Wraps saturates at 2^WRAP_W-1 and does not roll over.
  - Any other d: Error<=1, go to FAULT, Locked<=0.
    - Binary keeps the last good value; Step=0; Wraps and Overflow unchanged.
- State FAULT: behaviour depends on the optional feature (see below). Error is never cleared except by Reset.
- Only forward steps are legal; a -1 step is an error.
- Reset asserted mid-stream discards the reference value. The first sample after Reset only re-locks.

Optional Feature:
- Macro GRAY_TRACKER_RESYNC_EN.
- Defined:
  - In FAULT, the next En sample re-locks: Binary<=dec, Locked<=1, state goes to LOCKED.
  - No Step pulse on re-lock. Error stays 1 (sticky).
  - Subsequent tracking is identical to LOCKED.
- Not defined:
  - FAULT is terminal until Reset.
  - En is ignored in FAULT; Binary, Wraps and Overflow are frozen.

Test Plan:
- Full cycle (WIDTH=3), En=1 each cycle, GrayIn = 000,001,011,010,110,111,101,100,000:
  - First sample locks with Binary=0 and Step=0.
  - Next 8 samples give Binary 1..7 then 0, with Step=1 on each.
  - After the final sample: Overflow=1, Wraps=1, Error=0.
- Arbitrary start and repeat: GrayIn=101 -> Binary=6, Locked=1, Step=0. Then 101 again -> Binary=6, Step=0. Then 100 -> Binary=7, Step=1.
- Illegal jump: lock on 011 (Binary=2), then 110 -> Error=1, Locked=0, Binary=2. Later samples 111, 101 -> no change without the macro.
- Resync with GRAY_TRACKER_RESYNC_EN: after the illegal-jump sequence, sample 111 -> Locked=1, Binary=5, Error=1. Then 101 -> Binary=6, Step=1.
- En gating and reset: advance to Binary=4, then hold En=0 with GrayIn changing -> no change. Then assert Reset together with En=1 -> all outputs 0 and Locked=0 the next cycle.
- Wrap saturation (WRAP_W=2): feed 4 full cycles -> Wraps sticks at 3, Overflow=1.

Source files
------------

// File: rtl/gray_tracker.sv
// gray_tracker
//   Receive-side tracker for a Gray-coded counter. On each En strobe the
//   Gray input is decoded to binary. Each accepted sample must either repeat
//   the last value or advance it by exactly +1. The block counts wrap-arounds
//   and raises a sticky error on any illegal jump.
//
//   Ports:
//     Clk       clock, rising edge
//     Reset     synchronous, active-high reset (has priority over En)
//     En        sample strobe
//     GrayIn    Gray-coded count [WIDTH]
//     Binary    registered decode of the last accepted sample [WIDTH]
//     Step      one-cycle pulse after a legal +1 advance
//     Wraps     saturating count of all-ones -> zero advances [WRAP_W]
//     Overflow  sticky: at least one wrap since reset
//     Locked    tracker holds a valid reference value
//     Error     sticky: an illegal transition was seen
//
//   Optional feature macro: GRAY_TRACKER_RESYNC_EN
//     defined   : the first En sample after a fault re-locks onto the input
//                 (Error stays set)
//     undefined : the fault state is terminal until Reset
module gray_tracker #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic [WIDTH-1:0]  GrayIn,
  output logic [WIDTH-1:0]  Binary,
  output logic              Step,
  output logic [WRAP_W-1:0] Wraps,
  output logic              Overflow,
  output logic              Locked,
  output logic              Error
);

  typedef enum logic [1:0] {UNLOCKED, LOCKED, FAULT} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   dec, diff;
  logic [WIDTH-1:0]   bin_nxt;
  logic [WRAP_W-1:0]  wraps_nxt;
  logic               step_nxt, ovf_nxt, err_nxt;
  logic               rep, adv;

  // Each binary bit is the XOR of this Gray bit and every higher Gray bit.
  // Writing it as a reduction avoids a chained dependency through dec.
  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    assign dec[i] = ^(GrayIn >> i);
  end

  // Forward distance from the reference value, taken modulo 2^WIDTH.
  // A -1 step therefore appears as all ones and is classed as illegal.
  assign diff = dec - Binary;
  assign rep  = (diff == '0);
  assign adv  = (diff == WIDTH'(1));

  assign Locked = (state == LOCKED);

  // state register
  always_ff @(posedge Clk) begin
    if (Reset) state <= UNLOCKED;
    else       state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      UNLOCKED: if (En) state_nxt = LOCKED;
      LOCKED:   if (En && !rep && !adv) state_nxt = FAULT;
      FAULT: begin
`ifdef GRAY_TRACKER_RESYNC_EN
        if (En) state_nxt = LOCKED;
`else
        state_nxt = FAULT;
`endif
      end
      default:  state_nxt = UNLOCKED;
    endcase
  end

  // output next values; everything holds unless a sample changes it
  always_comb begin
    bin_nxt   = Binary;
    step_nxt  = 1'b0;
    wraps_nxt = Wraps;
    ovf_nxt   = Overflow;
    err_nxt   = Error;
    case (state)
      UNLOCKED: if (En) bin_nxt = dec;
      LOCKED: begin
        if (En) begin
          if (adv) begin
            bin_nxt  = dec;
            step_nxt = 1'b1;
            if (Binary == '1) begin
              ovf_nxt = 1'b1;
              if (Wraps != '1) wraps_nxt = Wraps + WRAP_W'(1);
            end
          end else if (!rep) begin
            // Binary keeps the last good value
            err_nxt = 1'b1;
          end
        end
      end
      FAULT: begin
`ifdef GRAY_TRACKER_RESYNC_EN
        if (En) bin_nxt = dec;
`endif
      end
      default: ;
    endcase
  end

  // output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Binary   <= '0;
      Step     <= 1'b0;
      Wraps    <= '0;
      Overflow <= 1'b0;
      Error    <= 1'b0;
    end else begin
      Binary   <= bin_nxt;
      Step     <= step_nxt;
      Wraps    <= wraps_nxt;
      Overflow <= ovf_nxt;
      Error    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_gray_tracker.sv
`timescale 1ns/1ps
// tb_gray_tracker
//   Scoreboard bench. Each stimulus vector pushes its hand-computed expected
//   output word, {Binary, Step, Wraps, Overflow, Locked, Error}. A separate
//   monitor pops one entry after every rising edge and compares it with the
//   DUT outputs. WRAP_W is set to 2 so that saturation is reachable.
module tb_gray_tracker;
  localparam int WIDTH  = 3;
  localparam int WRAP_W = 2;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              En = 1'b0;
  logic [WIDTH-1:0]  GrayIn = '0;
  logic [WIDTH-1:0]  Binary;
  logic              Step;
  logic [WRAP_W-1:0] Wraps;
  logic              Overflow, Locked, Error;

  gray_tracker #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .GrayIn(GrayIn),
    .Binary(Binary), .Step(Step), .Wraps(Wraps),
    .Overflow(Overflow), .Locked(Locked), .Error(Error)
  );

  always #5 Clk = ~Clk;

  typedef logic [WIDTH+WRAP_W+3:0] word_t;
  word_t expq[$];
  string nameq[$];
  int    checks = 0;
  int    errors = 0;

  // monitor: one expected word per sampling edge
  initial begin
    word_t e, a;
    string nm;
    forever begin
      @(posedge Clk);
      #1;
      if (expq.size() > 0) begin
        e  = expq.pop_front();
        nm = nameq.pop_front();
        a  = {Binary, Step, Wraps, Overflow, Locked, Error};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got bin=%b step=%b wraps=%b ovf=%b lock=%b err=%b, expected bin=%b step=%b wraps=%b ovf=%b lock=%b err=%b",
                   nm, a[8:6], a[5], a[4:3], a[2], a[1], a[0],
                   e[8:6], e[5], e[4:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // drive one cycle of stimulus and queue the expected outputs after the edge
  task automatic v(input logic r, input logic e, input logic [2:0] g,
                   input logic [2:0] b, input logic s, input logic [1:0] w,
                   input logic o, input logic l, input logic er,
                   input string nm);
    @(negedge Clk);
    Reset = r; En = e; GrayIn = g;
    expq.push_back({b, s, w, o, l, er});
    nameq.push_back(nm);
  endtask

  logic [2:0] gt [8];
  logic [1:0] wb [4];
  logic [1:0] wa [4];

  initial begin
    gt = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    // wraps during / after cycle c of the saturation run
    wb = '{2'd0, 2'd1, 2'd2, 2'd3};
    wa = '{2'd0, 2'd2, 2'd3, 2'd3};

    // reset state
    v(1, 0, 3'b000, 3'd0, 0, 2'd0, 0, 0, 0, "reset");

    // full cycle
    v(0, 1, 3'b000, 3'd0, 0, 2'd0, 0, 1, 0, "lock0");
    v(0, 1, 3'b001, 3'd1, 1, 2'd0, 0, 1, 0, "adv1");
    v(0, 1, 3'b011, 3'd2, 1, 2'd0, 0, 1, 0, "adv2");
    v(0, 1, 3'b010, 3'd3, 1, 2'd0, 0, 1, 0, "adv3");
    v(0, 1, 3'b110, 3'd4, 1, 2'd0, 0, 1, 0, "adv4");
    v(0, 1, 3'b111, 3'd5, 1, 2'd0, 0, 1, 0, "adv5");
    v(0, 1, 3'b101, 3'd6, 1, 2'd0, 0, 1, 0, "adv6");
    v(0, 1, 3'b100, 3'd7, 1, 2'd0, 0, 1, 0, "adv7");
    v(0, 1, 3'b000, 3'd0, 1, 2'd1, 1, 1, 0, "wrap1");

    // three more full cycles: Wraps 2, 3, then held at 3
    for (int c = 1; c <= 3; c++)
      for (int k = 1; k <= 8; k++)
        v(0, 1, gt[k%8], 3'(k%8), 1, (k == 8) ? wa[c] : wb[c], 1, 1, 0, "sat");

    // En low holds state; Step drops
    v(0, 0, 3'b011, 3'd0, 0, 2'd3, 1, 1, 0, "en0_hold");

    // reset together with En, then arbitrary start, repeat, advance
    v(1, 1, 3'b101, 3'd0, 0, 2'd0, 0, 0, 0, "rst_en");
    v(0, 1, 3'b101, 3'd6, 0, 2'd0, 0, 1, 0, "lock6");
    v(0, 1, 3'b101, 3'd6, 0, 2'd0, 0, 1, 0, "repeat6");
    v(0, 1, 3'b100, 3'd7, 1, 2'd0, 0, 1, 0, "adv7b");
    // a -1 step is illegal
    v(0, 1, 3'b101, 3'd7, 0, 2'd0, 0, 0, 1, "back_step");

    // illegal jump 2 -> 4
    v(1, 0, 3'b000, 3'd0, 0, 2'd0, 0, 0, 0, "rst2");
    v(0, 1, 3'b011, 3'd2, 0, 2'd0, 0, 1, 0, "lock2");
    v(0, 1, 3'b110, 3'd2, 0, 2'd0, 0, 0, 1, "jump");
`ifdef GRAY_TRACKER_RESYNC_EN
    v(0, 1, 3'b111, 3'd5, 0, 2'd0, 0, 1, 1, "resync");
    v(0, 1, 3'b101, 3'd6, 1, 2'd0, 0, 1, 1, "post_resync");
`else
    v(0, 1, 3'b111, 3'd2, 0, 2'd0, 0, 0, 1, "fault_hold1");
    v(0, 1, 3'b101, 3'd2, 0, 2'd0, 0, 0, 1, "fault_hold2");
`endif

    // En gating, then reset mid-stream
    v(1, 0, 3'b000, 3'd0, 0, 2'd0, 0, 0, 0, "rst3");
    v(0, 1, 3'b000, 3'd0, 0, 2'd0, 0, 1, 0, "g_lock0");
    v(0, 1, 3'b001, 3'd1, 1, 2'd0, 0, 1, 0, "g_adv1");
    v(0, 1, 3'b011, 3'd2, 1, 2'd0, 0, 1, 0, "g_adv2");
    v(0, 1, 3'b010, 3'd3, 1, 2'd0, 0, 1, 0, "g_adv3");
    v(0, 1, 3'b110, 3'd4, 1, 2'd0, 0, 1, 0, "g_adv4");
    v(0, 0, 3'b111, 3'd4, 0, 2'd0, 0, 1, 0, "g_hold1");
    v(0, 0, 3'b000, 3'd4, 0, 2'd0, 0, 1, 0, "g_hold2");
    v(1, 1, 3'b111, 3'd0, 0, 2'd0, 0, 0, 0, "g_rst_en");
    v(0, 1, 3'b111, 3'd5, 0, 2'd0, 0, 1, 0, "g_relock");
    v(0, 0, 3'b111, 3'd5, 0, 2'd0, 0, 1, 0, "g_idle");

    // let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge Clk);
    #2;
    if (expq.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
